// File: rtl/w3d_mmio_pkg.sv
// Shared types and constants for the MMIO-to-Avalon bridge.
package w3d_mmio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ,
        READ_WAIT,
        READ_RESP
    } w3d_mmio_state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Avalon slaves on this board only decode whole words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/w3d_mmio_timeout.sv
// Access watchdog: counts stalled cycles and flags when the budget is spent.
module w3d_mmio_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the limit so a late completion never sees a wrapped count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/w3d_mmio_avalon_bridge.sv
// AXI-Lite subset to single Avalon-MM master, one access in flight, with a
// per-access watchdog so a dead peripheral cannot stall the host bus.
module w3d_mmio_avalon_bridge
    import w3d_mmio_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    output logic        timeout_flag
);

    w3d_mmio_state_t state, state_nx;
    logic            tie_last_write, tie_last_write_nx;
    logic [31:0]     address_nx, writedata_nx, rdata_nx;
    logic            read_nx, write_nx, bvalid_nx, rvalid_nx, flag_nx;
    logic            write_req, read_req, grant_write, grant_read;
    logic            tmo_clr, tmo_en, tmo_expired;

    // The tie pointer only moves when both kinds actually contend.
    always_comb begin
        write_req   = s_awvalid & s_wvalid;
        read_req    = s_arvalid;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        if (state == IDLE) begin
            if (write_req && read_req) begin
                grant_write = !tie_last_write;
                grant_read  = tie_last_write;
            end else begin
                grant_write = write_req;
                grant_read  = read_req;
            end
        end
    end

    assign s_awready = grant_write;
    assign s_wready  = grant_write;
    assign s_arready = grant_read;

    assign tmo_clr = (state == IDLE);
    assign tmo_en  = (state == WRITE) || (state == READ) || (state == READ_WAIT);

    w3d_mmio_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_nx          = state;
        tie_last_write_nx = tie_last_write;
        address_nx        = avl_address;
        writedata_nx      = avl_writedata;
        rdata_nx          = s_rdata;
        read_nx           = avl_read;
        write_nx          = avl_write;
        bvalid_nx         = s_bvalid;
        rvalid_nx         = s_rvalid;
        flag_nx           = timeout_flag;
        case (state)
            IDLE: begin
                if (write_req && read_req) tie_last_write_nx = grant_write;
                if (grant_write) begin
                    address_nx   = word_align(s_awaddr);
                    writedata_nx = s_wdata;
                    write_nx     = 1'b1;
                    state_nx     = WRITE;
                end else if (grant_read) begin
                    address_nx = word_align(s_araddr);
                    read_nx    = 1'b1;
                    state_nx   = READ;
                end
            end
            WRITE: begin
                // Completion is checked first so it beats a coincident timeout.
                if (!avl_waitrequest || tmo_expired) begin
                    write_nx  = 1'b0;
                    bvalid_nx = 1'b1;
                    state_nx  = WRITE_RESP;
                    if (avl_waitrequest) flag_nx = 1'b1;
                end
            end
            WRITE_RESP: begin
                if (s_bready) begin
                    bvalid_nx = 1'b0;
                    state_nx  = IDLE;
                end
            end
            READ: begin
                if (!avl_waitrequest) begin
                    read_nx = 1'b0;
                    if (avl_readdatavalid) begin
                        rdata_nx  = avl_readdata;
                        rvalid_nx = 1'b1;
                        state_nx  = READ_RESP;
                    end else begin
                        state_nx = READ_WAIT;
                    end
                end else if (tmo_expired) begin
                    read_nx   = 1'b0;
                    rdata_nx  = ERR_DATA;
                    rvalid_nx = 1'b1;
                    flag_nx   = 1'b1;
                    state_nx  = READ_RESP;
                end
            end
            READ_WAIT: begin
                if (avl_readdatavalid) begin
                    rdata_nx  = avl_readdata;
                    rvalid_nx = 1'b1;
                    state_nx  = READ_RESP;
                end else if (tmo_expired) begin
                    rdata_nx  = ERR_DATA;
                    rvalid_nx = 1'b1;
                    flag_nx   = 1'b1;
                    state_nx  = READ_RESP;
                end
            end
            READ_RESP: begin
                if (s_rready) begin
                    rvalid_nx = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tie_last_write <= 1'b0;
            avl_address    <= '0;
            avl_writedata  <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            s_bvalid       <= 1'b0;
            s_rvalid       <= 1'b0;
            s_rdata        <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            state          <= state_nx;
            tie_last_write <= tie_last_write_nx;
            avl_address    <= address_nx;
            avl_writedata  <= writedata_nx;
            avl_read       <= read_nx;
            avl_write      <= write_nx;
            s_bvalid       <= bvalid_nx;
            s_rvalid       <= rvalid_nx;
            s_rdata        <= rdata_nx;
            timeout_flag   <= flag_nx;
        end
    end

endmodule

// File: tb/tb_w3d_mmio_avalon_bridge.sv
// Scoreboard bench for the MMIO-to-Avalon bridge.
module tb_w3d_mmio_avalon_bridge;

    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [31:0] avl_address, avl_writedata, avl_readdata;
    logic        avl_read, avl_write, avl_waitrequest, avl_readdatavalid;
    logic        timeout_flag;

    always #5 clk = ~clk;

    w3d_mmio_avalon_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (ERR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_awvalid         (s_awvalid),
        .s_awready         (s_awready),
        .s_awaddr          (s_awaddr),
        .s_wvalid          (s_wvalid),
        .s_wready          (s_wready),
        .s_wdata           (s_wdata),
        .s_bvalid          (s_bvalid),
        .s_bready          (s_bready),
        .s_arvalid         (s_arvalid),
        .s_arready         (s_arready),
        .s_araddr          (s_araddr),
        .s_rvalid          (s_rvalid),
        .s_rready          (s_rready),
        .s_rdata           (s_rdata),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .timeout_flag      (timeout_flag)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } avl_exp_t;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } resp_exp_t;

    avl_exp_t  sb_avl[$];
    resp_exp_t sb_resp[$];
    avl_exp_t  mon_ae;
    resp_exp_t mon_re;
    int        n_cmp = 0;
    int        n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon accesses are scored on their completing cycle, responses on handshake.
    always @(negedge clk) begin
        if (rst_n && (avl_write || avl_read) && !avl_waitrequest) begin
            if (sb_avl.size() == 0) begin
                check_eq("avl_unexpected_access", 32'(sb_avl.size()), 32'd1);
            end else begin
                mon_ae = sb_avl.pop_front();
                check_eq("avl_kind_is_write", 32'(avl_write), 32'(mon_ae.wr));
                check_eq("avl_address", avl_address, mon_ae.addr);
                if (mon_ae.wr) check_eq("avl_writedata", avl_writedata, mon_ae.data);
            end
        end
        if (rst_n && ((s_bvalid && s_bready) || (s_rvalid && s_rready))) begin
            if (sb_resp.size() == 0) begin
                check_eq("resp_unexpected", 32'(sb_resp.size()), 32'd1);
            end else begin
                mon_re = sb_resp.pop_front();
                check_eq("resp_kind_is_read", 32'(s_rvalid && s_rready), 32'(mon_re.rd));
                if (mon_re.rd) check_eq("resp_rdata", s_rdata, mon_re.data);
            end
        end
    end

    // Issues one transaction (other valids may already be pending), plays the
    // slave with 'waits' stall cycles (negative: stall forever) and read
    // latency 'lat' after release, then holds the response 'hold' cycles.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input int lat, input logic [31:0] rd_data,
                           input logic [31:0] exp_rdata, input int exp_strobes,
                           input int exp_vcycle, input int hold, input string tag);
        int        strobes = 0;
        int        vcycle  = 0;
        avl_exp_t  ae;
        resp_exp_t re;
        if (wr) begin
            s_awaddr  = addr;
            s_wdata   = wdata;
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
        end else begin
            s_araddr  = addr;
            s_arvalid = 1'b1;
        end
        avl_waitrequest   = (waits != 0);
        avl_readdatavalid = 1'b0;
        #1;
        check_eq({tag, "_grant"}, 32'({s_awready, s_wready, s_arready}), wr ? 32'd6 : 32'd1);
        if (waits >= 0) begin
            ae.wr   = wr;
            ae.addr = {addr[31:2], 2'b00};
            ae.data = wdata;
            sb_avl.push_back(ae);
        end
        re.rd   = !wr;
        re.data = exp_rdata;
        sb_resp.push_back(re);
        for (int c = 1; c <= 60 && vcycle == 0; c++) begin
            tick();
            if (c == 1) begin
                if (wr) begin
                    s_awvalid = 1'b0;
                    s_wvalid  = 1'b0;
                end else begin
                    s_arvalid = 1'b0;
                end
            end
            strobes += int'(wr ? avl_write : avl_read);
            if (wr ? s_bvalid : s_rvalid) vcycle = c;
            avl_waitrequest   = (waits < 0) || (c <= waits);
            avl_readdatavalid = !wr && (waits >= 0) && (c == waits + 1 + lat);
            avl_readdata      = rd_data;
        end
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b0;
        check_eq({tag, "_valid_cycle"}, 32'(vcycle), 32'(exp_vcycle));
        check_eq({tag, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
        if (!wr) check_eq({tag, "_rdata"}, s_rdata, exp_rdata);
        for (int h = 0; h < hold; h++) begin
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            s_arvalid = 1'b1;
            #1;
            check_eq({tag, "_hold_no_ready"}, 32'({s_awready, s_wready, s_arready}), 32'd0);
            check_eq({tag, "_hold_valid"}, 32'(wr ? s_bvalid : s_rvalid), 32'd1);
            if (!wr) check_eq({tag, "_hold_rdata"}, s_rdata, exp_rdata);
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
            s_arvalid = 1'b0;
            tick();
        end
        if (wr) s_bready = 1'b1;
        else    s_rready = 1'b1;
        tick();
        s_bready = 1'b0;
        s_rready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(wr ? s_bvalid : s_rvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0; avl_readdata = '0;
        tick();
        tick();
        check_eq("reset_ctrl", 32'({avl_read, avl_write, s_bvalid, s_rvalid, timeout_flag}), 32'd0);
        check_eq("reset_ready", 32'({s_awready, s_wready, s_arready}), 32'd0);
        check_eq("reset_address", avl_address, 32'd0);
        check_eq("reset_rdata", s_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write (unaligned address) and stalled read, each held 5 cycles.
        run_txn(1'b1, 32'h1000_0007, 32'hA5A5_0001, 0, 0, '0, '0, 1, 2, 5, "wr_basic");
        run_txn(1'b0, 32'h2000_0010, '0, 3, 2, 32'h1234_5678, 32'h1234_5678, 4, 7, 5, "rd_stall");

        // Two contended pairs: expect write, read, read, write.
        s_araddr = 32'h5000_0004; s_arvalid = 1'b1;
        run_txn(1'b1, 32'h5000_0100, 32'h1111_1111, 0, 0, '0, '0, 1, 2, 0, "tie1_w");
        run_txn(1'b0, 32'h5000_0004, '0, 0, 1, 32'h2222_2222, 32'h2222_2222, 1, 3, 0, "tie1_r");
        s_awaddr = 32'h5000_0200; s_wdata = 32'h3333_3333; s_awvalid = 1'b1; s_wvalid = 1'b1;
        run_txn(1'b0, 32'h5000_0008, '0, 0, 1, 32'h4444_4444, 32'h4444_4444, 1, 3, 0, "tie2_r");
        run_txn(1'b1, 32'h5000_0200, 32'h3333_3333, 0, 0, '0, '0, 1, 2, 0, "tie2_w");

        // Zero-latency read slave and a stalled write.
        run_txn(1'b0, 32'h6000_000B, '0, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 2, 0, "rd_zero_lat");
        run_txn(1'b1, 32'h6000_0020, 32'hCAFE_0002, 2, 0, '0, '0, 3, 4, 0, "wr_stall");

        // Dead slave: read aborts with ERR data; flag sticks across a good read.
        check_eq("flag_before_timeout", 32'(timeout_flag), 32'd0);
        run_txn(1'b0, 32'h7000_0000, '0, -1, 0, '0, ERR, TMO, TMO + 1, 0, "rd_timeout");
        check_eq("flag_after_timeout", 32'(timeout_flag), 32'd1);
        run_txn(1'b0, 32'h7000_0004, '0, 0, 1, 32'h5555_AAAA, 32'h5555_AAAA, 1, 3, 0, "rd_after_tmo");
        check_eq("flag_sticky", 32'(timeout_flag), 32'd1);

        // Asynchronous reset while waiting for read data.
        s_araddr = 32'h4000_0008; s_arvalid = 1'b1; avl_waitrequest = 1'b0;
        sb_avl.push_back('{wr: 1'b0, addr: 32'h4000_0008, data: 32'h0});
        tick();
        s_arvalid = 1'b0;
        tick();
        check_eq("rst_mid_read_strobe_dropped", 32'(avl_read), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_ctrl", 32'({avl_read, avl_write, s_bvalid, s_rvalid, timeout_flag}), 32'd0);
        check_eq("rst_async_address", avl_address, 32'd0);
        check_eq("rst_async_writedata", avl_writedata, 32'd0);
        check_eq("rst_async_rdata", s_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(1'b1, 32'h8000_0013, 32'h0F0F_F0F0, 1, 0, '0, '0, 2, 3, 0, "wr_after_rst");

        tick();
        check_eq("sb_avl_leftover", 32'(sb_avl.size()), 32'd0);
        check_eq("sb_resp_leftover", 32'(sb_resp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
